// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed display scanner with blanking guard, frame-aligned
// double-buffered value update and optional leading-zero suppression.
module seg_scan_ctrl #(
    parameter int DIV_CYC   = 50000,
    parameter int BLANK_CYC = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] din,
    input  logic        lzs,
    output logic [3:0]  nibble,
    output logic [3:0]  an,
    output logic        pending,
    output logic        frame_done
);

    localparam int MAX_CYC = (DIV_CYC > BLANK_CYC) ? DIV_CYC : BLANK_CYC;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CW-1:0] DIV_LAST   = CW'(DIV_CYC - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BLANK = 2'd1;
    localparam logic [1:0] SHOW  = 2'd2;

    logic [1:0]    state;
    logic [1:0]    idx;
    logic [CW-1:0] cnt;
    logic [15:0]   shadow;
    logic [15:0]   display;

    logic [3:0]    digit;
    logic [15:0]   upper;
    logic          suppressed;
    logic          boundary;

    assign digit      = display[{idx, 2'b00} +: 4];
    assign upper      = display >> {idx, 2'b00};
    assign suppressed = lzs && (idx != 2'd0) && (upper == 16'h0000);
    assign boundary   = (state == SHOW) && (idx == 2'd3) && (cnt == DIV_LAST);
    assign frame_done = boundary && en;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the later pending clear intentionally overrides the
    // earlier set unless a load arrives in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= 2'd0;
            cnt     <= '0;
            shadow  <= 16'h0000;
            display <= 16'h0000;
            pending <= 1'b0;
        end else begin
            if (load) begin
                shadow  <= din;
                pending <= 1'b1;
            end
            if (!en) begin
                state <= IDLE;
                idx   <= 2'd0;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= BLANK;
                        idx   <= 2'd0;
                        cnt   <= '0;
                    end
                    BLANK: begin
                        if (cnt == BLANK_LAST) begin
                            state <= SHOW;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    SHOW: begin
                        if (cnt == DIV_LAST) begin
                            state <= BLANK;
                            cnt   <= '0;
                            idx   <= idx + 2'd1;
                            // Frame boundary: old shadow moves to display even
                            // when a new load lands on this same edge.
                            if (idx == 2'd3 && pending) begin
                                display <= shadow;
                                if (!load) pending <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        idx   <= 2'd0;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    // NOTE: defaults first so every path assigns both outputs (no latches).
    always_comb begin
        an     = 4'hF;
        nibble = 4'h0;
        if (state != IDLE) nibble = digit;
        if (state == SHOW && !suppressed) an = ~(4'b0001 << idx);
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIV_CYC=4, BLANK_CYC=2 (24-cycle frame).
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [15:0] din;
    logic        lzs;
    logic [3:0]  nibble;
    logic [3:0]  an;
    logic        pending;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    // Hand-written anode pattern of one frame with all digits shown.
    logic [3:0] an_tab [24] = '{
        4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE,
        4'hF, 4'hF, 4'hD, 4'hD, 4'hD, 4'hD,
        4'hF, 4'hF, 4'hB, 4'hB, 4'hB, 4'hB,
        4'hF, 4'hF, 4'h7, 4'h7, 4'h7, 4'h7
    };

    seg_scan_ctrl #(.DIV_CYC(4), .BLANK_CYC(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .din        (din),
        .lzs        (lzs),
        .nibble     (nibble),
        .an         (an),
        .pending    (pending),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called right after the edge that starts cycle 1 of a frame; leaves the
    // bench right after the edge that starts cycle 1 of the next frame.
    task automatic run_frame(input string name, input logic [15:0] disp, input logic [3:0] sup,
                             input logic lz, input logic pend0,
                             input int la, input logic [15:0] da,
                             input int lb, input logic [15:0] db);
        for (int c = 1; c <= 24; c++) begin
            int d;
            logic [3:0] an_exp;
            logic [3:0] nib_exp;
            logic       pend_exp;
            #1;
            lzs  = lz;
            load = (c == la) || (c == lb);
            din  = (c == lb) ? db : da;
            d        = (c - 1) / 6;
            an_exp   = sup[d] ? 4'hF : an_tab[c-1];
            nib_exp  = disp[4*d +: 4];
            pend_exp = pend0 || (la != 0 && c > la) || (lb != 0 && c > lb);
            @(negedge clk);
            check($sformatf("%s an c%0d", name, c), {12'h0, an}, {12'h0, an_exp});
            check($sformatf("%s nibble c%0d", name, c), {12'h0, nibble}, {12'h0, nib_exp});
            check($sformatf("%s pending c%0d", name, c), {15'h0, pending}, {15'h0, pend_exp});
            check($sformatf("%s frame_done c%0d", name, c), {15'h0, frame_done}, {15'h0, c == 24});
            @(posedge clk);
        end
        #1 load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; load = 1'b1; din = 16'hFFFF; lzs = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset an", {12'h0, an}, 16'h000F);
        check("reset nibble", {12'h0, nibble}, 16'h0000);
        check("reset pending", {15'h0, pending}, 16'h0000);
        check("reset frame_done", {15'h0, frame_done}, 16'h0000);
        load = 1'b0; din = 16'h0000; en = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("idle an", {12'h0, an}, 16'h000F);
        en = 1'b1;
        @(posedge clk);

        run_frame("f1", 16'h0000, 4'b0000, 1'b0, 1'b0, 5, 16'h1234, 0, 16'h0);
        run_frame("f2", 16'h1234, 4'b0000, 1'b0, 1'b0, 3, 16'h0050, 0, 16'h0);
        run_frame("f3", 16'h0050, 4'b1100, 1'b1, 1'b0, 2, 16'h0000, 0, 16'h0);
        run_frame("f4", 16'h0000, 4'b1110, 1'b1, 1'b0, 0, 16'h0000, 0, 16'h0);
        run_frame("f5", 16'h0000, 4'b0000, 1'b0, 1'b0, 10, 16'h1111, 24, 16'hABCD);
        run_frame("f6", 16'h1111, 4'b0000, 1'b0, 1'b1, 0, 16'h0000, 0, 16'h0);
        run_frame("f7", 16'hABCD, 4'b0000, 1'b0, 1'b0, 0, 16'h0000, 0, 16'h0);

        // Reset in the SHOW phase of digit 2 with a load pending.
        load = 1'b1; din = 16'h5555;
        @(posedge clk);
        #1 load = 1'b0;
        repeat (13) @(posedge clk);
        @(negedge clk);
        check("pre-reset an", {12'h0, an}, 16'h000B);
        check("pre-reset nibble", {12'h0, nibble}, 16'h000B);
        check("pre-reset pending", {15'h0, pending}, 16'h0001);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid reset an", {12'h0, an}, 16'h000F);
        check("mid reset nibble", {12'h0, nibble}, 16'h0000);
        check("mid reset pending", {15'h0, pending}, 16'h0000);
        check("mid reset frame_done", {15'h0, frame_done}, 16'h0000);
        rst_n = 1'b1;
        @(posedge clk);
        run_frame("r1", 16'h0000, 4'b0000, 1'b0, 1'b0, 3, 16'h00A7, 0, 16'h0);
        run_frame("r2", 16'h00A7, 4'b0000, 1'b0, 1'b0, 0, 16'h0000, 0, 16'h0);

        // Disable during SHOW of digit 1, then load while idle.
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("pre-disable an", {12'h0, an}, 16'h000D);
        check("pre-disable nibble", {12'h0, nibble}, 16'h000A);
        en = 1'b0;
        @(posedge clk);
        #1;
        check("disable an", {12'h0, an}, 16'h000F);
        check("disable nibble", {12'h0, nibble}, 16'h0000);
        check("disable frame_done", {15'h0, frame_done}, 16'h0000);
        load = 1'b1; din = 16'h0042;
        @(posedge clk);
        #1 load = 1'b0;
        @(negedge clk);
        check("idle load pending", {15'h0, pending}, 16'h0001);
        check("idle load an", {12'h0, an}, 16'h000F);
        check("idle load nibble", {12'h0, nibble}, 16'h0000);
        en = 1'b1;
        @(posedge clk);
        run_frame("r3", 16'h00A7, 4'b0000, 1'b0, 1'b1, 0, 16'h0000, 0, 16'h0);
        run_frame("r4", 16'h0042, 4'b0000, 1'b0, 1'b0, 0, 16'h0000, 0, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
